// File: rtl/imm_gen_stage.sv
// RISC-V immediate generation stage: decodes the immediate format, extends it to XLEN,
// and buffers results in a two-entry skid buffer with flush and an illegal-opcode counter.
module imm_gen_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtZ    = 3'd6;
  localparam logic [2:0] FmtSh   = 3'd7;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, new_entry;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fmt;
  logic             illegal;
  logic [31:0]      imm32;
  logic             accept, pop;

  always_comb begin
    fmt     = FmtNone;
    illegal = 1'b0;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: fmt = FmtU;
      7'b1101111:             fmt = FmtJ;
      7'b1100111, 7'b0000011: fmt = FmtI;
      7'b0100011:             fmt = FmtS;
      7'b1100011:             fmt = FmtB;
      7'b0010011:             fmt = (in_instr[13:12] == 2'b01) ? FmtSh : FmtI;
      7'b1110011:             fmt = in_instr[14] ? FmtZ : FmtNone;
      7'b0110011, 7'b0001111: fmt = FmtNone;
      default:                illegal = 1'b1;
    endcase
  end

  // SH and Z leave bit 31 clear, so a single sign extension below serves every format.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FmtI:    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FmtS:    imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FmtB:    imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FmtJ:    imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      FmtU:    imm32 = {in_instr[31:12], 12'b0};
      FmtSh:   imm32 = {27'b0, in_instr[24:20]};
      FmtZ:    imm32 = {27'b0, in_instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    new_entry.imm     = XLEN'($signed(imm32));
    new_entry.fmt     = fmt;
    new_entry.illegal = illegal;
    new_entry.tag     = in_tag;
  end

  assign accept = in_valid && in_ready_q;
  assign pop    = (state_q != StEmpty) && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) begin
          main_d  = new_entry;
          state_d = StOne;
        end
        StOne: begin
          if (accept && pop) begin
            main_d = new_entry;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: if (pop) begin
          main_d  = skid_q;
          state_d = StOne;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!flush && accept && new_entry.illegal && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StTwo);
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != StEmpty);
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed scenarios plus randomized traffic against a queue model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [4:0]  out_tag;
  logic [7:0]  illegal_cnt;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [4:0]  out_tag64;
  logic [7:0]  illegal_cnt64;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag),
    .illegal_cnt(illegal_cnt)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(5), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
    .out_tag(out_tag64), .illegal_cnt(illegal_cnt64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   cnt_m;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference immediate built from field arithmetic on a sign-extended copy of the word.
  function automatic exp_t model(logic [31:0] ins, logic [4:0] tag);
    exp_t   e;
    longint s;
    s     = longint'($signed(ins));
    e.tag = tag;
    e.ill = 1'b0;
    e.fmt = 3'd0;
    e.imm = 64'd0;
    case (ins[6:0])
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = s & ~longint'(4095); end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = ((s >>> 31) << 20) | (((s >> 12) & 255) << 12) | (((s >> 20) & 1) << 11)
              | (((s >> 21) & 1023) << 1);
      end
      7'h67, 7'h03: begin e.fmt = 3'd1; e.imm = s >>> 20; end
      7'h23: begin e.fmt = 3'd2; e.imm = ((s >>> 25) << 5) | ((s >> 7) & 31); end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = ((s >>> 31) << 12) | (((s >> 7) & 1) << 11) | (((s >> 25) & 63) << 5)
              | (((s >> 8) & 15) << 1);
      end
      7'h13: begin
        if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
          e.fmt = 3'd7; e.imm = (s >> 20) & 31;
        end else begin
          e.fmt = 3'd1; e.imm = s >>> 20;
        end
      end
      7'h73: if (ins[14]) begin e.fmt = 3'd6; e.imm = (s >> 15) & 31; end
      7'h33, 7'h0F: e.fmt = 3'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] tag,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_tag    = tag;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance the model by one clock using the currently driven inputs, then step to the negedge.
  task automatic tick();
    logic acc, pop;
    exp_t e;
    acc = in_valid && (q.size() < 2);
    pop = out_ready && (q.size() > 0);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = model(in_instr, in_tag);
        q.push_back(e);
        if (e.ill && cnt_m < 255) cnt_m++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    n_chk++;
    if (out_imm !== 32'd0 || out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_tag !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_out: imm=%h fmt=%0d ill=%b tag=%0d want zeros",
               out_imm, out_fmt, out_illegal, out_tag);
    end
    n_chk++;
    if (illegal_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", illegal_cnt);
    end
  endtask

  task automatic test_addi();
    drive(1, 32'hFFF00093, 5'd1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    n_chk++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1) begin
      n_fail++;
      $display("FAIL addi32: v=%b imm=%h fmt=%0d want 1 ffffffff 1", out_valid, out_imm, out_fmt);
    end
    n_chk++;
    if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
      n_fail++; $display("FAIL addi64: imm=%h want ffffffffffffffff", out_imm64);
    end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3] = '{32'hFE000EE3, 32'h123450B7, 32'h001000EF};
    logic [31:0] imm [3] = '{32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    logic [2:0]  fmt [3] = '{3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 3; i++) begin
      drive(1, ins[i], 5'(i + 4), 1, 0); tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_imm !== imm[i] || out_fmt !== fmt[i]
          || out_tag !== 5'(i + 4)) begin
        n_fail++;
        $display("FAIL b2b_%0d: v=%b imm=%h fmt=%0d tag=%0d want 1 %h %0d %0d", i, out_valid,
                 out_imm, out_fmt, out_tag, imm[i], fmt[i], i + 4);
      end
    end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_shift_csr();
    drive(1, 32'h4030D093, 5'd2, 1, 0); tick();
    n_chk++;
    if (out_imm !== 32'd3 || out_fmt !== 3'd7) begin
      n_fail++; $display("FAIL srai: imm=%h fmt=%0d want 3 7", out_imm, out_fmt);
    end
    drive(1, 32'h300FD073, 5'd3, 1, 0); tick();
    n_chk++;
    if (out_imm !== 32'h1F || out_fmt !== 3'd6 || out_imm64 !== 64'h1F) begin
      n_fail++; $display("FAIL csrrwi: imm=%h fmt=%0d want 1f 6", out_imm, out_fmt);
    end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_backpressure();
    drive(1, 32'h00100093, 5'd10, 0, 0); tick();
    drive(1, 32'h00200093, 5'd11, 0, 0); tick();
    drive(1, 32'h00300093, 5'd12, 0, 0);
    n_chk++;
    if (in_ready !== 1'b0 || out_tag !== 5'd10) begin
      n_fail++; $display("FAIL bp_full: ready=%b tag=%0d want 0 10", in_ready, out_tag);
    end
    tick();
    n_chk++;
    if (in_ready !== 1'b0 || out_imm !== 32'd1 || out_tag !== 5'd10) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b imm=%h tag=%0d want 0 1 10", in_ready, out_imm, out_tag);
    end
    for (int t = 10; t <= 12; t++) begin
      drive(t < 12, 32'h00300093, 5'd12, 1, 0);
      n_chk++;
      if (out_valid !== 1'b1 || out_tag !== 5'(t) || out_imm !== 32'(t - 9)) begin
        n_fail++;
        $display("FAIL bp_order_%0d: v=%b tag=%0d imm=%h want 1 %0d %0d", t, out_valid, out_tag,
                 out_imm, t, t - 9);
      end
      tick();
    end
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1, 32'h00100093, 5'd1, 0, 0); tick();
    drive(1, 32'h00200093, 5'd2, 0, 0); tick();
    drive(1, 32'h00300093, 5'd3, 0, 1); tick();
    drive(0, 0, 0, 0, 0);
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    int k = 0;
    for (int i = 0; i < 301; i++) begin
      if (i == 10) begin
        drive(1, 32'h0000007F, 5'd9, 1, 1); tick();
        n_chk++;
        if (illegal_cnt !== 8'd10 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL ill_flush: cnt=%0d v=%b want 10 0", illegal_cnt, out_valid);
        end
      end else begin
        drive(1, 32'h0000007F | (i << 7), 5'(i), 1, 0); tick();
        k++;
        n_chk++;
        if (out_illegal !== 1'b1 || out_fmt !== 3'd0 || out_imm !== 32'd0
            || illegal_cnt !== 8'((k > 255) ? 255 : k)) begin
          n_fail++;
          $display("FAIL ill_%0d: ill=%b fmt=%0d imm=%h cnt=%0d want 1 0 0 %0d", i, out_illegal,
                   out_fmt, out_imm, illegal_cnt, (k > 255) ? 255 : k);
        end
      end
    end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h123450B7, 5'd7, 0, 0); tick();
    drive(1, 32'hFFF00093, 5'd8, 0, 0); tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'd0 || out_tag !== 5'd0
        || out_fmt !== 3'd0 || illegal_cnt !== 8'd0 || out_imm64 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b rdy=%b imm=%h tag=%0d fmt=%0d cnt=%0d want 0 1 0 0 0 0",
               out_valid, in_ready, out_imm, out_tag, out_fmt, illegal_cnt);
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    cnt_m = 0;
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h73, 7'h33};
    logic [31:0] ins;
    for (int c = 0; c < 600; c++) begin
      n_chk++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)
          || illegal_cnt !== 8'(cnt_m)) begin
        n_fail++;
        $display("FAIL rnd_ctl_%0d: rdy=%b v=%b cnt=%0d want %b %b %0d", c, in_ready, out_valid,
                 illegal_cnt, q.size() < 2, q.size() > 0, cnt_m);
      end
      if (q.size() > 0) begin
        n_chk++;
        if (out_imm !== q[0].imm[31:0] || out_imm64 !== q[0].imm || out_fmt !== q[0].fmt
            || out_illegal !== q[0].ill || out_tag !== q[0].tag) begin
          n_fail++;
          $display("FAIL rnd_data_%0d: imm=%h imm64=%h fmt=%0d ill=%b tag=%0d want %h %0d %b %0d",
                   c, out_imm, out_imm64, out_fmt, out_illegal, out_tag, q[0].imm, q[0].fmt,
                   q[0].ill, q[0].tag);
        end
      end
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
      drive($urandom_range(0, 3) != 0, ins, 5'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_m = 0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_addi();
    test_back_to_back();
    test_shift_csr();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
